// File: rtl/pmu_counter_bank.sv
// pmu_counter_bank: bank of event counters, each fed by a programmable event select,
// with sticky wrap-around overflow flags and a maskable, registered overflow interrupt.
// Accessed through a single-cycle register port (1-cycle read latency).
// Optional feature: define PMU_SNAPSHOT_EN to add CTRL.SNAP and the SNAP_i registers.
module pmu_counter_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned N_COUNTERS = 16,
  parameter int unsigned N_EVENTS   = 19,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_EVENTS-1:0]   events_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  int_overflow_o
);

  localparam int unsigned EvselBase = 4;
  localparam int unsigned CntBase   = 4 + N_COUNTERS;

  logic [N_EVENTS-1:0]   events_q;
  logic                  en_q;
  logic [N_COUNTERS-1:0] ovf_q, ovf_d, ovf_set, ovf_w1c, mask_q;
  logic [7:0]            evsel_q [N_COUNTERS];
  logic [CNT_WIDTH-1:0]  cnt_q   [N_COUNTERS];
  logic [CNT_WIDTH-1:0]  cnt_d   [N_COUNTERS];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_val, snap_rd_val;
  logic                  rd_valid_q, int_q;
  logic [255:0]          ev_pad;
  logic                  ctrl_wr, clr;
  int unsigned           wa, ra;

  assign wa      = 32'(wr_addr_i);
  assign ra      = 32'(rd_addr_i);
  assign ctrl_wr = wr_en_i && (wa == 0);
  assign clr     = ctrl_wr && wr_data_i[1];
  assign ovf_w1c = (wr_en_i && (wa == 1)) ? wr_data_i[N_COUNTERS-1:0] : '0;

  // Zero padding makes any select >= N_EVENTS read a constant 0, so it never counts.
  assign ev_pad = 256'(events_q);

  // Per-counter next value: clear beats CPU write beats increment.
  always_comb begin
    ovf_set = '0;
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (wr_en_i && (wa == CntBase + i)) begin
        cnt_d[i] = wr_data_i[CNT_WIDTH-1:0];
      end else if (en_q && ev_pad[evsel_q[i]]) begin
        cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
        ovf_set[i] = &cnt_q[i];
      end
    end
  end

  // Sticky overflow flags; a new wrap wins over a simultaneous write-1-to-clear.
  always_comb begin
    ovf_d = clr ? '0 : ((ovf_q & ~ovf_w1c) | ovf_set);
  end

`ifdef PMU_SNAPSHOT_EN
  localparam int unsigned SnapBase = 4 + 2 * N_COUNTERS;

  logic [CNT_WIDTH-1:0] snap_q [N_COUNTERS];
  logic                 snap_req;

  assign snap_req = ctrl_wr && wr_data_i[2];

  // Capture the post-update counter values so every snapshot comes from the same edge.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      if (rst_i) begin
        snap_q[i] <= '0;
      end else if (snap_req) begin
        snap_q[i] <= cnt_d[i];
      end
    end
  end

  // Snapshot read decode.
  always_comb begin
    snap_rd_val = '0;
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      if (ra == SnapBase + i) snap_rd_val = DATA_WIDTH'(snap_q[i]);
    end
  end
`else
  assign snap_rd_val = '0;
`endif

  // Read decode against the pre-write state; unmapped addresses return 0.
  always_comb begin
    rd_val = snap_rd_val;
    if (ra == 0) rd_val = DATA_WIDTH'(en_q);
    if (ra == 1) rd_val = DATA_WIDTH'(ovf_q);
    if (ra == 2) rd_val = DATA_WIDTH'(mask_q);
    if (ra == 3) begin
      rd_val = DATA_WIDTH'({10'd0, 6'(CNT_WIDTH), 8'(N_EVENTS - 1), 8'(N_COUNTERS)});
    end
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      if (ra == EvselBase + i) rd_val = DATA_WIDTH'(evsel_q[i]);
      if (ra == CntBase + i)   rd_val = DATA_WIDTH'(cnt_q[i]);
    end
  end

  // All architectural state, event pipeline and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      events_q   <= '0;
      en_q       <= 1'b0;
      ovf_q      <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      int_q      <= 1'b0;
      for (int unsigned i = 0; i < N_COUNTERS; i++) begin
        evsel_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      events_q   <= events_i;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_en_i;
      rd_data_q  <= rd_en_i ? rd_val : '0;
      int_q      <= |(ovf_q & mask_q);
      if (ctrl_wr) en_q <= wr_data_i[0];
      if (wr_en_i && (wa == 2)) mask_q <= wr_data_i[N_COUNTERS-1:0];
      for (int unsigned i = 0; i < N_COUNTERS; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (wr_en_i && (wa == EvselBase + i)) evsel_q[i] <= wr_data_i[7:0];
      end
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign int_overflow_o = int_q;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Self-checking bench for pmu_counter_bank (default parameters). A behavioural model
// tracks the register map; a negedge process compares every output each cycle, and
// directed reads pin the model to hand-computed values. Honours PMU_SNAPSHOT_EN.
module tb_pmu_counter_bank;

  localparam int NC = 16;
  localparam int NE = 19;
`ifdef PMU_SNAPSHOT_EN
  localparam bit SnapOn = 1'b1;
`else
  localparam bit SnapOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NE-1:0] events_i = '0;
  logic          wr_en_i = 1'b0;
  logic [6:0]    wr_addr_i = '0;
  logic [31:0]   wr_data_i = '0;
  logic          rd_en_i = 1'b0;
  logic [6:0]    rd_addr_i = '0;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o;
  logic          int_overflow_o;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  pmu_counter_bank dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .events_i       (events_i),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .rd_en_i        (rd_en_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .int_overflow_o (int_overflow_o)
  );

  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_cnt  [NC];
  logic [31:0] m_snap [NC];
  logic [7:0]  m_evsel[NC];
  logic [15:0] m_ovf, m_mask;
  logic        m_en;
  logic [NE-1:0] m_evq;
  logic        exp_valid, exp_int;
  logic [31:0] exp_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return {31'b0, m_en};
    if (a == 1) return {16'b0, m_ovf};
    if (a == 2) return {16'b0, m_mask};
    if (a == 3) return 32'h0020_1210;
    if (a >= 4 && a < 4 + NC) return {24'b0, m_evsel[a-4]};
    if (a >= 4 + NC && a < 4 + 2 * NC) return m_cnt[a-4-NC];
    if (SnapOn && a >= 4 + 2 * NC && a < 4 + 3 * NC) return m_snap[a-4-2*NC];
    return 32'h0;
  endfunction

  // Behavioural model, advanced once per rising edge.
  always @(posedge clk) begin : model
    int a;
    int sel;
    bit clr;
    logic [15:0] setf;
    if (rst_i) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = 0; m_snap[i] = 0; m_evsel[i] = 0;
      end
      m_ovf = 0; m_mask = 0; m_en = 0; m_evq = 0;
      exp_valid = 0; exp_rdata = 0; exp_int = 0;
    end else begin
      a = int'(wr_addr_i);
      exp_valid = rd_en_i;
      if (rd_en_i) exp_rdata = model_read(int'(rd_addr_i));
      exp_int = (m_ovf & m_mask) != 0;
      clr = wr_en_i && a == 0 && wr_data_i[1];
      setf = 0;
      for (int i = 0; i < NC; i++) begin
        sel = int'(m_evsel[i]);
        if (clr) m_cnt[i] = 0;
        else if (wr_en_i && a == 4 + NC + i) m_cnt[i] = wr_data_i;
        else if (m_en && sel < NE && m_evq[sel]) begin
          if (m_cnt[i] == 32'hFFFF_FFFF) begin
            m_cnt[i] = 0;
            setf[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (clr) m_ovf = 0;
      else begin
        if (wr_en_i && a == 1) m_ovf = m_ovf & ~wr_data_i[15:0];
        m_ovf = m_ovf | setf;
      end
      if (wr_en_i) begin
        if (a == 0) m_en = wr_data_i[0];
        if (a == 2) m_mask = wr_data_i[15:0];
        if (a >= 4 && a < 4 + NC) m_evsel[a-4] = wr_data_i[7:0];
      end
      if (SnapOn && wr_en_i && a == 0 && wr_data_i[2]) begin
        for (int i = 0; i < NC; i++) m_snap[i] = m_cnt[i];
      end
      m_evq = events_i;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("rd_valid", {31'b0, rd_valid_o}, {31'b0, exp_valid});
      if (exp_valid) check("rd_data", rd_data_o, exp_rdata);
      check("int_overflow", {31'b0, int_overflow_o}, {31'b0, exp_int});
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = 7'(a); wr_data_i = d;
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  task automatic rd_lit(input string name, input int a, input logic [31:0] req);
    rd_en_i = 1'b1; rd_addr_i = 7'(a);
    @(negedge clk);
    rd_en_i = 1'b0;
    check(name, rd_data_o, req);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int sel;
    idle(2);
    chk_on = 1'b1;
    rst_i = 1'b0;

    // Reset state and INFO
    rd_lit("info", 3, 32'h0020_1210);
    check("int_reset", {31'b0, int_overflow_o}, 32'h0);
    for (int i = 0; i < NC; i++) rd_lit("cnt_reset", 4 + NC + i, 32'h0);

    // Counter 0 on event 5 for 10 cycles
    wr(4, 5);
    wr(0, 1);
    events_i[5] = 1'b1;
    idle(10);
    events_i = '0;
    idle(2);
    rd_lit("cnt0_ten", 20, 32'd10);
    for (int i = 1; i < NC; i++) rd_lit("cnt_other_zero", 20 + i, 32'h0);

    // Wrap on counter 3 with interrupt, then W1C
    wr(23, 32'hFFFF_FFFE);
    wr(7, 0);
    wr(2, 32'h8);
    repeat (3) begin
      events_i[0] = 1'b1;
      @(negedge clk);
      events_i[0] = 1'b0;
      @(negedge clk);
    end
    idle(2);
    rd_lit("cnt3_wrapped", 23, 32'd1);
    rd_lit("ovf_status", 1, 32'h8);
    check("int_high", {31'b0, int_overflow_o}, 32'h1);
    wr(1, 32'h8);
    check("int_hold", {31'b0, int_overflow_o}, 32'h1);
    idle(1);
    check("int_low", {31'b0, int_overflow_o}, 32'h0);

    // Out-of-range event select never counts
    wr(21, 0);
    wr(5, 200);
    events_i = '1;
    idle(5);
    events_i = '0;
    idle(2);
    rd_lit("evsel_oob", 21, 32'h0);

    // CPU write beats a simultaneous increment
    events_i[0] = 1'b1;
    @(negedge clk);
    events_i = '0;
    wr(22, 100);
    idle(1);
    rd_lit("wr_beats_inc", 22, 32'd100);

    // CLR while counting, with an overflow flag pending
    wr(24, 32'hFFFF_FFFF);
    events_i = '1;
    idle(3);
    rd_lit("ovf_pre_clr", 1, 32'h10);
    events_i = '0;
    wr(0, 3);
    idle(1);
    rd_lit("ovf_clr", 1, 32'h0);
    for (int i = 0; i < NC; i++) rd_lit("cnt_clr", 20 + i, 32'h0);
    rd_lit("evsel_kept", 4, 32'd5);
    rd_lit("ctrl_en_kept", 0, 32'h1);

    // Snapshot
    events_i[5] = 1'b1;
    idle(7);
    events_i = '0;
    idle(2);
    wr(0, 5);
    events_i[5] = 1'b1;
    idle(4);
    events_i = '0;
    idle(2);
    rd_lit("snap0", 4 + 2 * NC, SnapOn ? 32'd7 : 32'd0);
    rd_lit("cnt0_after_snap", 20, 32'd11);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      events_i = NE'($urandom);
      rst_i = ($urandom_range(0, 599) == 0);
      wr_en_i = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0: begin
          wr_addr_i = 7'd0;
          wr_data_i = {29'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 7) != 0)};
        end
        1: begin wr_addr_i = 7'd1; wr_data_i = $urandom; end
        2: begin wr_addr_i = 7'd2; wr_data_i = $urandom; end
        3: begin wr_addr_i = 7'($urandom_range(0, 127)); wr_data_i = $urandom; end
        4, 5: begin
          wr_addr_i = 7'(4 + $urandom_range(0, NC - 1));
          wr_data_i = ($urandom_range(0, 3) == 0) ? 32'd200 : 32'($urandom_range(0, 22));
        end
        default: begin
          wr_addr_i = 7'(4 + NC + $urandom_range(0, NC - 1));
          wr_data_i = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
        end
      endcase
      rd_en_i = ($urandom_range(0, 1) == 0);
      rd_addr_i = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 55));
      @(negedge clk);
    end
    rst_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;

    // Reset mid-operation with events in flight
    wr(0, 1);
    events_i = '1;
    idle(1);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    events_i = '0;
    idle(2);
    rd_lit("cnt0_after_rst", 20, 32'h0);
    rd_lit("ctrl_after_rst", 0, 32'h0);
    rd_lit("info_after_rst", 3, 32'h0020_1210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pmu_counter_bank.md
# pmu_counter_bank

Parametrised event-counter bank for the performance monitoring unit: N_COUNTERS counters, each selecting any one of N_EVENTS event lines through a programmable select register, with sticky wrap-around overflow flags and a maskable overflow interrupt. It sits behind the PMU's bus adapter on a simple single-cycle register port. It replaces the fixed one-counter-per-event arrangement with a flexible event-to-counter mapping.

## Interface
- DATA_WIDTH, 32, register port data width.
- ADDR_WIDTH, 7, word address width; must satisfy 4 + 3*N_COUNTERS <= 2^ADDR_WIDTH.
- N_COUNTERS, 16, number of counters (1..32).
- N_EVENTS, 19, number of event inputs (2..256).
- CNT_WIDTH, 32, counter width (8..DATA_WIDTH).
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous and active-high.
- events_i  in  N_EVENTS  event pulses, one count per high cycle.
- wr_en_i  in  1  write strobe.
- wr_addr_i  in  ADDR_WIDTH  write word address.
- wr_data_i  in  DATA_WIDTH  write data.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  ADDR_WIDTH  read word address.
- rd_data_o  out  DATA_WIDTH  read data, valid with rd_valid_o.
- rd_valid_o  out  1  read data valid.
- int_overflow_o  out  1  OR of (OVF_STATUS & OVF_MASK).

## Operation
- Register map (word addresses):
  - 0x00 CTRL: bit0 EN (global count enable); bit1 CLR (write-1, self-clearing, reads 0); bit2 SNAP (write-1, self-clearing, reads 0; SNAP configuration only).
  - 0x01 OVF_STATUS: bit i = counter i wrapped; sticky; write-1-to-clear.
  - 0x02 OVF_MASK: bit i enables interrupt for counter i.
  - 0x03 INFO, read-only: [7:0] N_COUNTERS, [15:8] N_EVENTS-1, [21:16] CNT_WIDTH.
  - 0x04+i EVSEL_i: [7:0] event index for counter i.
  - 0x04+N_COUNTERS+i CNT_i: counter value, read/write.
  - 0x04+2*N_COUNTERS+i SNAP_i: snapshot value, read-only (SNAP configuration only).
- events_i is registered once (events_q). Counter i increments by 1 when EN=1 and events_q[EVSEL_i]=1.
- EVSEL_i >= N_EVENTS: counter i never increments.
- Counter at all-ones and incrementing: wraps to 0 and sets OVF_STATUS[i] in the same cycle.
- Priority per counter: rst_i, then CLR, then CPU write to CNT_i, then increment. A write in the same cycle as an increment loads the written value; that increment is lost.
- CLR zeroes all counters and OVF_STATUS. EVSEL, OVF_MASK and EN are unchanged.
- OVF_STATUS: a new overflow set wins over a simultaneous W1C of the same bit.
- Writes truncate to the register width. Reads zero-extend. Unmapped addresses: writes are ignored, reads return 0.
- Simultaneous wr_en_i and rd_en_i to the same address: the read returns the pre-write value.

## Timing
- Reset values: all counters, EVSEL, OVF_STATUS, OVF_MASK, CTRL and snapshots are 0. rd_data_o=0, rd_valid_o=0, int_overflow_o=0.
- Event-to-count latency: 2 cycles. An event high at edge n is registered at n+1; CNT_i updates at edge n+2.
- Writes take effect at the next edge. A write of EN=1 at edge n allows counting from events_q sampled at edge n+1.
- Read latency: 1 cycle. rd_valid_o is a single-cycle pulse following each rd_en_i. Back-to-back reads are supported every cycle.
- int_overflow_o is registered. It rises one cycle after OVF_STATUS/OVF_MASK produce a set AND term, and falls one cycle after the term clears.
- rst_i asserted mid-operation returns all state to reset values at the next edge. Events in the pipeline are discarded.

## Configuration
- PMU_SNAPSHOT_EN defined: CTRL.SNAP copies every counter into SNAP_i at the same edge. The copy takes the post-increment values of that edge, so the result is atomic across all counters.
- PMU_SNAPSHOT_EN undefined: no snapshot registers exist. SNAP_i addresses read 0. CTRL bit2 is ignored and reads 0.

## Test plan
- Reset, then read 0x03 with defaults -> rd_data_o=0x0020_1210 one cycle later with rd_valid_o=1. All counters read 0; int_overflow_o=0.
- Set EVSEL_0=5 and EN=1, drive events_i[5] high for 10 cycles -> CNT_0=10; all other counters stay 0.
- Set CNT_3=0xFFFF_FFFE, EVSEL_3=0, OVF_MASK=0x8, EN=1, pulse events_i[0] 3 times -> CNT_3=1 and OVF_STATUS=0x8. int_overflow_o goes high one cycle after the wrap. W1C 0x8 to OVF_STATUS -> int_overflow_o low one cycle later.
- Set EVSEL_1=200 with N_EVENTS=19, hold all events high -> CNT_1 stays 0.
- Write CNT_2=100 in the same cycle as a counted event -> CNT_2=100. Then assert CLR while counting -> all counters=0 next cycle and OVF_STATUS=0.
- With PMU_SNAPSHOT_EN: count 7 events on counter 0, write SNAP, keep counting 4 more -> SNAP_0=7 and CNT_0=11. Without PMU_SNAPSHOT_EN: SNAP_0 reads 0.
